red_pitaya_iq_gain_ramper: RTL
==============================

Name: red_pitaya_iq_gain_ramper

Overview:
- Sequencer that drives the four gain inputs (g1..g4) of the IQ modulator block.
- Moves all four gains from their present values to new targets in bounded linear steps at a programmable rate, so the modulator output changes without glitches.
- Signals busy/done to the register bank. Sits between the IQ register bank and the modulator gain ports.

Parameters:
- GAINBITS, 16, signed gain width; matches modulator gain ports.
- STEPBITS, 16, unsigned step-size width.
- DIVBITS, 16, unsigned prescaler width.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- tgt1_i..tgt4_i  in  GAINBITS each  signed target gains.
- step_i  in  STEPBITS  unsigned max change per update; 0 = jump directly to target.
- div_i  in  DIVBITS  update period minus one, in clk_i cycles.
- start_i  in  1  one-cycle pulse: latch targets/step/div, begin ramp.
- abort_i  in  1  one-cycle pulse: freeze gains, stop ramp.
- g1_o..g4_o  out  GAINBITS each  registered gains to the modulator.
- busy_o  out  1  high while state is RAMP.
- done_o  out  1  one-cycle pulse when all gains reach target.

Behaviour:
- Reset: g1_o..g4_o=0, busy_o=0, done_o=0, state=IDLE, prescaler=0, latched targets=0.
- States:
  - IDLE: start_i -> RAMP. On the same edge, latch tgt1..4, step, div; clear prescaler. Gains unchanged.
  - RAMP: prescaler counts 0..div_latched.
    - tick = (prescaler == div_latched); prescaler wraps to 0 on tick.
    - On a tick edge, each channel updates: d = tgt - g, computed at GAINBITS+1 bits.
    - If step==0 or |d| <= step: g = tgt. Otherwise g = g ± step, sign of d.
    - Never overshoots; all arithmetic stays in GAINBITS+1/STEPBITS+1, so no wrap-around.
    - Step is zero-extended. A step >= full range behaves as a jump.
  - Completion: if after the tick update all four g == tgt, the same edge sets state=IDLE and done_o=1 for exactly one cycle. done_o coincides with the final gain values.
- Latency: start_i sampled at edge N -> first gain update visible after edge N+2+div.
  - div=0: one update per cycle after edge N+2.
  - All four channels update on the same edge.
- Targets already equal to gains at start: no gain change; done_o at edge N+2+div.
- start_i while RAMP (retarget):
  - Relatch targets/step/div and clear the prescaler.
  - Gains continue from their current values; no done_o for the abandoned target.
- abort_i: from any state -> IDLE next edge. Gains hold, busy_o=0, no done_o.
  - abort_i and start_i on the same cycle: abort wins, start ignored.
- Changes on tgt*/step/div inputs while RAMP are ignored until the next start_i.
- rst_i mid-ramp: immediate return to reset values on the next edge, including gains=0.
- busy_o = (state==RAMP), registered.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared header of localparams: state encoding IDLE=0, RAMP=1.
- One natural sub-module, red_pitaya_gain_step: combinational next value from (g, tgt, step) with the no-overshoot clamp. Instantiated as a 4-element array.
- Top level holds the FSM, prescaler, latches and output registers.

Test Plan:
- Ramp up: g=0, tgt1=1000, others 0, step=100, div=0, start at N -> g1 goes 100,200,...,1000 on edges N+2..N+11. done_o high at N+11 only; busy_o low after.
- Ramp down with clamp: g1=1000, tgt1=-250, step=300, div=3 -> g1=700,400,100,-200,-250, one update every 4 cycles. No value below -250.
- Jump and full scale: step=0, tgt1..4 = 32767, -32768, 0, 12345 -> all four set on the first tick (edge N+2). done_o on the same edge; no overflow.
- Abort mid-ramp: ramp 0->1000 step 100, abort after g1=300 -> g1 holds 300, busy_o=0, done_o never asserted. Simultaneous start+abort in IDLE -> stays IDLE.
- Retarget: during ramp to 1000 at g1=400, start with tgt1=0, step 200 -> g1=200,0, then done_o. Exactly one done_o.
- Reset mid-ramp: rst_i asserted at g1=500 -> next edge all g=0, busy_o=0, done_o=0. Ramp restarts cleanly on a later start_i.

Source files
------------

// File: rtl/red_pitaya_iq_gain_ramper_pkg.sv
// Shared definitions for the IQ gain ramper.
// Holds the FSM state encoding, the channel count and default widths,
// plus a small width helper used when sizing internal arithmetic.
package red_pitaya_iq_gain_ramper_pkg;

  localparam int NUM_CH       = 4;
  localparam int DEF_GAINBITS = 16;
  localparam int DEF_STEPBITS = 16;
  localparam int DEF_DIVBITS  = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/red_pitaya_iq_gain_ramper_if.sv
// Bundle between the IQ register bank (master) and the gain ramper (slave).
// Master drives targets, step size, prescaler period and the start/abort
// pulses; slave returns the four registered gains plus busy and done.
interface red_pitaya_iq_gain_ramper_if #(
  parameter int GAINBITS = 16,
  parameter int STEPBITS = 16,
  parameter int DIVBITS  = 16
);

  logic signed [GAINBITS-1:0] tgt1_i, tgt2_i, tgt3_i, tgt4_i;
  logic        [STEPBITS-1:0] step_i;
  logic        [DIVBITS-1:0]  div_i;
  logic                       start_i;
  logic                       abort_i;
  logic signed [GAINBITS-1:0] g1_o, g2_o, g3_o, g4_o;
  logic                       busy_o;
  logic                       done_o;

  modport master (
    output tgt1_i, tgt2_i, tgt3_i, tgt4_i, step_i, div_i, start_i, abort_i,
    input  g1_o, g2_o, g3_o, g4_o, busy_o, done_o
  );

  modport slave (
    input  tgt1_i, tgt2_i, tgt3_i, tgt4_i, step_i, div_i, start_i, abort_i,
    output g1_o, g2_o, g3_o, g4_o, busy_o, done_o
  );

endinterface

// File: rtl/red_pitaya_gain_step.sv
// One channel of the ramp: purely combinational next gain value.
// Ports: g_i current gain, tgt_i target gain, step_i unsigned max change
// (0 means jump), next_o gain after one update, never past the target.
module red_pitaya_gain_step
  import red_pitaya_iq_gain_ramper_pkg::*;
#(
  parameter int GAINBITS = DEF_GAINBITS,
  parameter int STEPBITS = DEF_STEPBITS
) (
  input  logic signed [GAINBITS-1:0] g_i,
  input  logic signed [GAINBITS-1:0] tgt_i,
  input  logic        [STEPBITS-1:0] step_i,
  output logic signed [GAINBITS-1:0] next_o
);

  // Wide enough for a full-range difference and a zero-extended step, so
  // neither the distance nor g +/- step can ever wrap.
  localparam int W = max2(GAINBITS, STEPBITS) + 2;

  logic signed [W-1:0] g_w, tgt_w, diff_w, mag_w, step_w;

  // Jump when the remaining distance fits in one step (or step is 0),
  // otherwise move one step towards the target.
  always_comb begin
    g_w    = W'(g_i);
    tgt_w  = W'(tgt_i);
    step_w = W'(step_i);
    diff_w = tgt_w - g_w;
    mag_w  = diff_w[W-1] ? -diff_w : diff_w;
    if ((step_i == '0) || (mag_w <= step_w)) begin
      next_o = tgt_i;
    end else if (diff_w[W-1]) begin
      next_o = GAINBITS'(g_w - step_w);
    end else begin
      next_o = GAINBITS'(g_w + step_w);
    end
  end

endmodule

// File: rtl/red_pitaya_iq_gain_ramper.sv
// Gain ramp sequencer for the IQ modulator: moves g1..g4 to new targets in
// bounded linear steps, one update per prescaler period.
// Ports: clk_i/rst_i (synchronous, active high), bus (slave side of the
// ramper interface: targets, step, div, start/abort in; gains, busy, done out).
module red_pitaya_iq_gain_ramper
  import red_pitaya_iq_gain_ramper_pkg::*;
#(
  parameter int GAINBITS = DEF_GAINBITS,
  parameter int STEPBITS = DEF_STEPBITS,
  parameter int DIVBITS  = DEF_DIVBITS
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  red_pitaya_iq_gain_ramper_if.slave   bus
);

  state_e                     state_q, state_d;
  logic        [DIVBITS-1:0]  presc_q, presc_d;
  logic        [DIVBITS-1:0]  div_q, div_d;
  logic        [STEPBITS-1:0] step_q, step_d;
  logic                       arm_q, arm_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic signed [GAINBITS-1:0] tgt_q [NUM_CH];
  logic signed [GAINBITS-1:0] tgt_d [NUM_CH];
  logic signed [GAINBITS-1:0] g_q   [NUM_CH];
  logic signed [GAINBITS-1:0] g_d   [NUM_CH];
  logic signed [GAINBITS-1:0] g_nxt [NUM_CH];
  logic signed [GAINBITS-1:0] tgt_in [NUM_CH];
  logic                       all_hit;

  assign tgt_in[0] = bus.tgt1_i;
  assign tgt_in[1] = bus.tgt2_i;
  assign tgt_in[2] = bus.tgt3_i;
  assign tgt_in[3] = bus.tgt4_i;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    red_pitaya_gain_step #(
      .GAINBITS (GAINBITS),
      .STEPBITS (STEPBITS)
    ) u_step (
      .g_i    (g_q[i]),
      .tgt_i  (tgt_q[i]),
      .step_i (step_q),
      .next_o (g_nxt[i])
    );
  end

  // True when the pending update lands every channel on its target.
  always_comb begin
    all_hit = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (g_nxt[i] != tgt_q[i]) all_hit = 1'b0;
    end
  end

  // Abort beats start; start (from IDLE or mid-ramp) relatches and arms.
  // arm_q burns one cycle after start so the first tick lands at N+2+div.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    div_d   = div_q;
    step_d  = step_q;
    arm_d   = arm_q;
    done_d  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      tgt_d[i] = tgt_q[i];
      g_d[i]   = g_q[i];
    end
    if (bus.abort_i) begin
      state_d = ST_IDLE;
      arm_d   = 1'b0;
    end else if (bus.start_i) begin
      state_d = ST_RAMP;
      presc_d = '0;
      div_d   = bus.div_i;
      step_d  = bus.step_i;
      arm_d   = 1'b1;
      for (int i = 0; i < NUM_CH; i++) tgt_d[i] = tgt_in[i];
    end else if (state_q == ST_RAMP) begin
      if (arm_q) begin
        arm_d = 1'b0;
      end else if (presc_q == div_q) begin
        presc_d = '0;
        for (int i = 0; i < NUM_CH; i++) g_d[i] = g_nxt[i];
        if (all_hit) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    busy_d = (state_d == ST_RAMP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      div_q   <= '0;
      step_q  <= '0;
      arm_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        tgt_q[i] <= '0;
        g_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      div_q   <= div_d;
      step_q  <= step_d;
      arm_q   <= arm_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int i = 0; i < NUM_CH; i++) begin
        tgt_q[i] <= tgt_d[i];
        g_q[i]   <= g_d[i];
      end
    end
  end

  assign bus.g1_o   = g_q[0];
  assign bus.g2_o   = g_q[1];
  assign bus.g3_o   = g_q[2];
  assign bus.g4_o   = g_q[3];
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;

endmodule
